// File: rtl/ofm_relu_pool_if.sv
// ---------------------------------------------------------------------------
// ofm_relu_pool_if
//   Pixel stream bundle between the convolution core output, the ReLU /
//   requantize / 2x2 max-pool stage and the next layer's IFM loader.
//
//   Signals:
//     in_valid   : In_OFM carries a valid OFM pixel this cycle
//     In_OFM     : 13-bit two's-complement OFM pixel, raster order
//     out_valid  : Out_POOL valid this cycle (single-cycle pulse per window)
//     Out_POOL   : 8-bit unsigned pooled pixel (0 when out_valid = 0)
//     frame_done : pulse coincident with the last pooled output of a frame
//     Sat_cnt    : saturated-pixel count of the current frame
//                  (only when OFM_SAT_CNT_EN is defined)
//
//   Modports:
//     master : stream producer / result consumer (the bench or upstream glue)
//     slave  : the pooling block
// ---------------------------------------------------------------------------
interface ofm_relu_pool_if;
    logic        in_valid;
    logic [12:0] In_OFM;
    logic        out_valid;
    logic [7:0]  Out_POOL;
    logic        frame_done;
`ifdef OFM_SAT_CNT_EN
    logic [15:0] Sat_cnt;
`endif

`ifdef OFM_SAT_CNT_EN
    modport master (output in_valid, In_OFM,
                    input  out_valid, Out_POOL, frame_done, Sat_cnt);
    modport slave  (input  in_valid, In_OFM,
                    output out_valid, Out_POOL, frame_done, Sat_cnt);
`else
    modport master (output in_valid, In_OFM,
                    input  out_valid, Out_POOL, frame_done);
    modport slave  (input  in_valid, In_OFM,
                    output out_valid, Out_POOL, frame_done);
`endif
endinterface

// File: rtl/ofm_relu_pool.sv
// ---------------------------------------------------------------------------
// ofm_relu_pool
//   ReLU + requantization (arithmetic shift, saturate to 8 bits) followed by
//   2x2 stride-2 max-pooling of a raster-order OFM stream. Even-column pixels
//   are held in a register; on odd columns of even rows the pair maximum is
//   parked in a half-width line buffer; on odd columns of odd rows the full
//   window maximum is registered out with one cycle of latency.
//
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : ofm_relu_pool_if.slave (in_valid/In_OFM in,
//             out_valid/Out_POOL/frame_done[/Sat_cnt] out)
//
//   Parameters:
//     MAP_W : OFM width  in pixels (even, >= 2)
//     MAP_H : OFM height in pixels (even, >= 2)
//     SHIFT : requantization right shift after ReLU (0..12)
//
//   Optional feature macro: OFM_SAT_CNT_EN
//     When defined, bus.Sat_cnt counts pixels clipped at 255 in the current
//     frame, sticks at 16'hFFFF, holds its value during the frame_done cycle
//     and restarts on the following cycle.
// ---------------------------------------------------------------------------
module ofm_relu_pool #(
    parameter int MAP_W = 8,
    parameter int MAP_H = 8,
    parameter int SHIFT = 3
) (
    input logic             clk,
    input logic             rst_n,
    ofm_relu_pool_if.slave  bus
);

    localparam int CW    = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int RW    = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int LB_N  = MAP_W / 2;
    localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    hold_q, hold_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_pool_q, out_pool_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    linebuf_q [LB_N];

    // -----------------------------------------------------------------------
    // Pixel transform q(x): ReLU, shift, saturate
    // -----------------------------------------------------------------------
    logic signed [12:0] pix_s;
    logic signed [12:0] pix_shr;
    logic               pix_sat;
    logic [7:0]         pix_q;

    always_comb begin
        pix_s   = signed'(bus.In_OFM);
        pix_shr = pix_s >>> SHIFT;
        pix_sat = 1'b0;
        if (pix_s[12]) begin
            pix_q = 8'd0;
        end else if (pix_shr > 13'sd255) begin
            pix_q   = 8'd255;
            pix_sat = 1'b1;
        end else begin
            pix_q = pix_shr[7:0];
        end
    end

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // -----------------------------------------------------------------------
    // Line buffer addressing: one entry per column pair
    // -----------------------------------------------------------------------
    logic [LB_AW-1:0] lb_idx;
    logic [7:0]       lb_rdata;
    logic [7:0]       pair_max;
    logic             lb_we;
    logic             last_col;
    logic             last_row;

    assign lb_idx   = LB_AW'(col_q >> 1);
    assign lb_rdata = linebuf_q[lb_idx];
    assign pair_max = max8(hold_q, pix_q);
    assign last_col = (col_q == CW'(MAP_W - 1));
    assign last_row = (row_q == RW'(MAP_H - 1));

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        lb_we        = 1'b0;
        out_valid_d  = 1'b0;
        out_pool_d   = 8'd0;
        frame_done_d = 1'b0;

        if (bus.in_valid) begin
            if (!col_q[0]) begin
                hold_d = pix_q;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_valid_d  = 1'b1;
                out_pool_d   = max8(lb_rdata, pair_max);
                frame_done_d = last_row && last_col;
            end

            // Raster counters; wrap straight into the next frame.
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= 8'd0;
            out_valid_q  <= 1'b0;
            out_pool_q   <= 8'd0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            out_valid_q  <= out_valid_d;
            out_pool_q   <= out_pool_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the line buffer has no reset; each entry is written by an even
    // row before the following odd row reads it, so its contents never leak.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= pair_max;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.Out_POOL   = out_pool_q;
    assign bus.frame_done = frame_done_q;

`ifdef OFM_SAT_CNT_EN
    // -----------------------------------------------------------------------
    // Saturation counter: held through the frame_done cycle, then restarted.
    // A saturating pixel of the new frame accepted in that same cycle is the
    // first count of the next frame.
    // -----------------------------------------------------------------------
    logic [15:0] sat_cnt_q, sat_cnt_d;
    logic        sat_inc;

    assign sat_inc = bus.in_valid && pix_sat;

    always_comb begin
        if (frame_done_q) begin
            sat_cnt_d = sat_inc ? 16'd1 : 16'd0;
        end else if (sat_inc && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= 16'd0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign bus.Sat_cnt = sat_cnt_q;
`endif

endmodule
